issue_throttle_ctrl: RTL and testbench
======================================

# issue_throttle_ctrl

Parametrised per-SM issue-budget throttle running entirely in the clk_sm domain. Once per update period it samples each SM's supply-voltage reading and converts it into a clamped per-window issue budget. Once per budget window it reloads each SM's remaining-issue counter from that budget, then debits the issues reported each cycle. It drives per-SM remaining, stall and overrun outputs to the SM issue stages, and removes the divided controller clock used by the previous generation.

## Interface
- NUM_SM, 16: number of SM lanes.
- VW, 8: voltage reading width.
- IW, 5: issue count / budget width.
- WINDOW, 10: SM cycles per budget window; must be ≥2.
- UPDATE_PERIOD, 20: SM cycles between budget recomputations; must be ≥2.
- MAX_BUDGET, 20: budget at zero voltage reading; must be < 2**IW.
- MIN_BUDGET, 1: floor on computed budget; must be ≤ MAX_BUDGET.
- VDIV, 10: voltage divisor; must be ≥1.

- clk_sm  in  1  SM clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- voltage  in  NUM_SM*VW  per-SM voltage reading; lane i at [i*VW +: VW].
- issued  in  NUM_SM*IW  per-SM instructions issued this cycle.
- throttle_en  in  NUM_SM  per-SM enable; 0 forces the budget to MAX_BUDGET.
- remaining  out  NUM_SM*IW  per-SM issues left in the current window.
- budget  out  NUM_SM*IW  per-SM latched budget.
- stall  out  NUM_SM  remaining[i]==0.
- overrun  out  NUM_SM  one-cycle pulse when issued[i] > remaining[i].
- update_pulse  out  1  one-cycle pulse on the cycle after budgets load.

## Operation
- Global upd_cnt counts 0..UPDATE_PERIOD-1 and wraps.
- Budget load: on the edge where upd_cnt==UPDATE_PERIOD-1, each lane loads its new budget:
  - throttle_en[i]=0: budget = MAX_BUDGET.
  - throttle_en[i]=1: budget = max(MIN_BUDGET, MAX_BUDGET − voltage[i]/VDIV).
  - Compute the subtraction in signed width max(VW,IW)+2. There is no wrap: a large voltage clamps to MIN_BUDGET.
- Global win_cnt counts 0..WINDOW-1 and wraps.
- Window reload: on the edge where win_cnt==WINDOW-1, remaining[i] ← budget[i], using the budget register value before this edge.
- Debit: on every other edge, remaining[i] ← remaining[i] − issued[i], saturating at 0.
- overrun[i] is registered and asserts for one cycle when issued[i] > remaining[i] was sampled at that edge. This applies on reload edges too; the issues are charged to the closing window and discarded.
- throttle_en changes take effect at the next budget load only.

## Timing
- Reset values:
  - upd_cnt=0, win_cnt=0.
  - budget=MAX_BUDGET and remaining=MAX_BUDGET for all lanes.
  - stall=0, overrun=0, update_pulse=0.
- First reload at edge WINDOW after reset release; first budget load at edge UPDATE_PERIOD.
- Budget latency: a voltage sampled at a load edge reaches remaining at the next reload edge strictly after it. When both counters hit terminal on the same edge, the reload uses the old budget and the new budget is used one window later.
- update_pulse is high for exactly the cycle following each load edge.
- stall is combinational from the remaining register, so it has zero latency from that register.
- rst mid-window abandons the window, restores reset values and restarts both counters from 0.
- issued=0 for a whole window: remaining holds its value and stall stays 0, unless budget is 0. That case is impossible while MIN_BUDGET ≥ 1.

## Structure
- Package issue_throttle_pkg holds:
  - default parameter constants (MAX_BUDGET, MIN_BUDGET, VDIV, WINDOW, UPDATE_PERIOD);
  - function calc_budget(voltage, en), which applies the clamp rules above.
- Sub-module issue_budget_lane holds one lane: budget register, remaining register, saturating debit, overrun and stall. It is instantiated NUM_SM times via a generate loop.
- The top level owns upd_cnt, win_cnt and update_pulse, and broadcasts the load and reload strobes to the lanes.
- Elaboration-time assertions enforce all parameter constraints.

## Test plan
- Reset, then voltage=0 and issued=0 on all lanes. Required: remaining=20 throughout, budget=20 after edge 20, update_pulse high at cycle 21, stall=0.
- Lane 0: voltage=55, throttle_en=1, issued=3 per cycle. Required: budget=15 after edge 20; from reload edge 30, remaining steps 15,12,9,6,3,0. stall asserts once remaining=0, and overrun pulses on the next nonzero issue.
- Lane 3: voltage=255. Required: budget clamps to MIN_BUDGET=1 with no wrap. The same lane with throttle_en=0 gets budget=20.
- issued=7 while remaining=4. Required: remaining=0, overrun high for exactly one cycle. Issue on the reload edge: remaining=budget and nothing is debited.
- Assert rst mid-window with remaining=6. Required: next cycle remaining=20 and counters 0; the next reload is WINDOW edges after rst deasserts.
- Run NUM_SM=4, WINDOW=5, UPDATE_PERIOD=5 so both counters hit terminal on the same edge. Required: the reload uses the old budget, and the new budget appears at the next reload.

Source files
------------

// File: rtl/issue_throttle_pkg.sv
// Shared defaults and budget conversion for the SM issue throttle.
package issue_throttle_pkg;

  localparam int DEF_MAX_BUDGET    = 20;
  localparam int DEF_MIN_BUDGET    = 1;
  localparam int DEF_VDIV          = 10;
  localparam int DEF_WINDOW        = 10;
  localparam int DEF_UPDATE_PERIOD = 20;

  // Voltage reading to per-window budget. The math is done in 32-bit signed,
  // wide enough that a large reading goes negative and clamps rather than wraps.
  function automatic int calc_budget(input int volt, input logic en,
                                     input int max_b, input int min_b,
                                     input int vdiv);
    int b;
    if (!en) return max_b;
    b = max_b - (volt / vdiv);
    return (b < min_b) ? min_b : b;
  endfunction

endpackage

// File: rtl/issue_throttle_ctrl_lane.sv
// One SM lane: latched budget, remaining-issue counter, overrun and stall.
module issue_budget_lane
  import issue_throttle_pkg::*;
#(
  parameter int VW         = 8,
  parameter int IW         = 5,
  parameter int MAX_BUDGET = DEF_MAX_BUDGET,
  parameter int MIN_BUDGET = DEF_MIN_BUDGET,
  parameter int VDIV       = DEF_VDIV
) (
  input  logic          clk_sm,
  input  logic          rst,
  input  logic          load,
  input  logic          reload,
  input  logic          en,
  input  logic [VW-1:0] voltage,
  input  logic [IW-1:0] issued,
  output logic [IW-1:0] budget,
  output logic [IW-1:0] remaining,
  output logic          stall,
  output logic          overrun
);

  logic [IW-1:0] budget_d, budget_q;
  logic [IW-1:0] remaining_d, remaining_q;
  logic          overrun_d, overrun_q;

  // Next budget / remaining / overrun; reload takes the pre-edge budget and
  // discards any issues reported on that edge.
  always_comb begin
    budget_d    = budget_q;
    remaining_d = remaining_q;
    overrun_d   = issued > remaining_q;
    if (load)
      budget_d = IW'(calc_budget(int'({1'b0, voltage}), en,
                                 MAX_BUDGET, MIN_BUDGET, VDIV));
    if (reload)
      remaining_d = budget_q;
    else if (issued > remaining_q)
      remaining_d = '0;
    else
      remaining_d = remaining_q - issued;
  end

  // Lane state registers.
  always_ff @(posedge clk_sm) begin
    if (rst) begin
      budget_q    <= IW'(MAX_BUDGET);
      remaining_q <= IW'(MAX_BUDGET);
      overrun_q   <= 1'b0;
    end else begin
      budget_q    <= budget_d;
      remaining_q <= remaining_d;
      overrun_q   <= overrun_d;
    end
  end

  assign budget    = budget_q;
  assign remaining = remaining_q;
  assign overrun   = overrun_q;
  assign stall     = (remaining_q == '0);

endmodule

// File: rtl/issue_throttle_ctrl.sv
// Per-SM issue-budget throttle: global update/window counters feeding NUM_SM lanes.
module issue_throttle_ctrl
  import issue_throttle_pkg::*;
#(
  parameter int NUM_SM        = 16,
  parameter int VW            = 8,
  parameter int IW            = 5,
  parameter int WINDOW        = DEF_WINDOW,
  parameter int UPDATE_PERIOD = DEF_UPDATE_PERIOD,
  parameter int MAX_BUDGET    = DEF_MAX_BUDGET,
  parameter int MIN_BUDGET    = DEF_MIN_BUDGET,
  parameter int VDIV          = DEF_VDIV
) (
  input  logic                 clk_sm,
  input  logic                 rst,
  input  logic [NUM_SM*VW-1:0] voltage,
  input  logic [NUM_SM*IW-1:0] issued,
  input  logic [NUM_SM-1:0]    throttle_en,
  output logic [NUM_SM*IW-1:0] remaining,
  output logic [NUM_SM*IW-1:0] budget,
  output logic [NUM_SM-1:0]    stall,
  output logic [NUM_SM-1:0]    overrun,
  output logic                 update_pulse
);

  localparam int UW = $clog2(UPDATE_PERIOD);
  localparam int WW = $clog2(WINDOW);

  if (WINDOW < 2)                begin : g_chk_window $error("WINDOW must be >= 2"); end
  if (UPDATE_PERIOD < 2)         begin : g_chk_upd    $error("UPDATE_PERIOD must be >= 2"); end
  if (MAX_BUDGET >= (1 << IW))   begin : g_chk_max    $error("MAX_BUDGET must fit in IW bits"); end
  if (MIN_BUDGET > MAX_BUDGET)   begin : g_chk_min    $error("MIN_BUDGET must be <= MAX_BUDGET"); end
  if (VDIV < 1)                  begin : g_chk_vdiv   $error("VDIV must be >= 1"); end
  if (VW > 30)                   begin : g_chk_vw     $error("VW too wide for budget math"); end

  logic [UW-1:0] upd_cnt_d, upd_cnt_q;
  logic [WW-1:0] win_cnt_d, win_cnt_q;
  logic          update_pulse_d, update_pulse_q;
  logic          load, reload;

  assign load   = (upd_cnt_q == UW'(UPDATE_PERIOD - 1));
  assign reload = (win_cnt_q == WW'(WINDOW - 1));

  // Wrapping period counters; update_pulse trails the load edge by one cycle.
  always_comb begin
    upd_cnt_d      = load   ? '0 : upd_cnt_q + UW'(1);
    win_cnt_d      = reload ? '0 : win_cnt_q + WW'(1);
    update_pulse_d = load;
  end

  // Global counter registers.
  always_ff @(posedge clk_sm) begin
    if (rst) begin
      upd_cnt_q      <= '0;
      win_cnt_q      <= '0;
      update_pulse_q <= 1'b0;
    end else begin
      upd_cnt_q      <= upd_cnt_d;
      win_cnt_q      <= win_cnt_d;
      update_pulse_q <= update_pulse_d;
    end
  end

  assign update_pulse = update_pulse_q;

  for (genvar i = 0; i < NUM_SM; i++) begin : g_lane
    issue_budget_lane #(
      .VW(VW), .IW(IW), .MAX_BUDGET(MAX_BUDGET),
      .MIN_BUDGET(MIN_BUDGET), .VDIV(VDIV)
    ) u_lane (
      .clk_sm    (clk_sm),
      .rst       (rst),
      .load      (load),
      .reload    (reload),
      .en        (throttle_en[i]),
      .voltage   (voltage[i*VW +: VW]),
      .issued    (issued[i*IW +: IW]),
      .budget    (budget[i*IW +: IW]),
      .remaining (remaining[i*IW +: IW]),
      .stall     (stall[i]),
      .overrun   (overrun[i])
    );
  end

endmodule

// File: tb/tb_issue_throttle_ctrl.sv
// Scoreboard bench: driver queues hand-computed expectations per cycle,
// monitor pops and compares them at the falling edge.
module tb_issue_throttle_ctrl;

  localparam int NA = 16, NB = 4, VW = 8, IW = 5;

  typedef enum int {S_REM, S_BUD, S_STALL, S_OVR, S_UPD, S_REMB, S_BUDB, S_UPDB} sig_e;
  typedef struct {int phase; int cyc; sig_e sig; int lane; int val;} exp_t;

  logic clk_sm = 1'b0;
  logic rst;
  logic [NA*VW-1:0] v_a;
  logic [NA*IW-1:0] iss_a, rem_a, bud_a;
  logic [NA-1:0]    en_a, stall_a, ovr_a;
  logic             upd_a;
  logic [NB*VW-1:0] v_b;
  logic [NB*IW-1:0] iss_b, rem_b, bud_b;
  logic [NB-1:0]    en_b, stall_b, ovr_b;
  logic             upd_b;

  exp_t q[$];
  int phase, ecnt;
  int n_tests = 0, n_fail = 0;
  bit done = 0;

  always #5 clk_sm = ~clk_sm;

  issue_throttle_ctrl u_a (
    .clk_sm(clk_sm), .rst(rst), .voltage(v_a), .issued(iss_a), .throttle_en(en_a),
    .remaining(rem_a), .budget(bud_a), .stall(stall_a), .overrun(ovr_a),
    .update_pulse(upd_a));

  issue_throttle_ctrl #(.NUM_SM(NB), .WINDOW(5), .UPDATE_PERIOD(5)) u_b (
    .clk_sm(clk_sm), .rst(rst), .voltage(v_b), .issued(iss_b), .throttle_en(en_b),
    .remaining(rem_b), .budget(bud_b), .stall(stall_b), .overrun(ovr_b),
    .update_pulse(upd_b));

  task automatic ex(input sig_e s, input int lane, input int val);
    exp_t e;
    e.phase = phase; e.cyc = ecnt; e.sig = s; e.lane = lane; e.val = val;
    q.push_back(e);
  endtask

  function automatic int act(input sig_e s, input int lane);
    case (s)
      S_REM:   return int'(rem_a[lane*IW +: IW]);
      S_BUD:   return int'(bud_a[lane*IW +: IW]);
      S_STALL: return int'(stall_a[lane]);
      S_OVR:   return int'(ovr_a[lane]);
      S_UPD:   return int'(upd_a);
      S_REMB:  return int'(rem_b[lane*IW +: IW]);
      S_BUDB:  return int'(bud_b[lane*IW +: IW]);
      default: return int'(upd_b);
    endcase
  endfunction

  // Hand-computed expectations for the state after edge ecnt of the phase.
  task automatic push_exp();
    if (phase == 1) begin
      case (ecnt)
        0:  begin ex(S_REM,0,20); ex(S_REM,15,20); ex(S_BUD,0,20); ex(S_STALL,0,0);
                  ex(S_OVR,0,0); ex(S_UPD,0,0); ex(S_REMB,0,20); ex(S_BUDB,0,20); end
        4:  ex(S_BUDB,0,20);
        5:  begin ex(S_REMB,0,20); ex(S_BUDB,0,10); ex(S_UPDB,0,1); end
        9:  ex(S_REMB,0,20);
        10: begin ex(S_REM,0,20); ex(S_REMB,0,10); end
        19: begin ex(S_UPD,0,0); ex(S_BUD,0,20); end
        20: begin ex(S_UPD,0,1); ex(S_BUD,0,15); ex(S_BUD,3,1); ex(S_BUD,5,4);
                  ex(S_BUD,7,20); ex(S_REM,0,20); end
        21: ex(S_UPD,0,0);
        29: ex(S_REM,0,20);
        30: begin ex(S_REM,0,15); ex(S_OVR,0,0); ex(S_REM,3,1); ex(S_REM,5,4);
                  ex(S_REM,7,20); ex(S_STALL,3,0); end
        31: ex(S_REM,0,12);
        32: begin ex(S_REM,0,9); ex(S_REM,5,0); ex(S_OVR,5,1); end
        33: begin ex(S_REM,0,6); ex(S_OVR,5,0); ex(S_STALL,5,1); end
        34: ex(S_REM,0,3);
        35: begin ex(S_REM,0,0); ex(S_STALL,0,1); ex(S_OVR,0,0); end
        36: begin ex(S_REM,0,0); ex(S_OVR,0,1); end
        37: begin ex(S_OVR,0,0); ex(S_STALL,0,1); end
        39: begin ex(S_BUD,3,1); ex(S_REM,3,1); ex(S_STALL,5,1); end
        40: begin ex(S_UPD,0,1); ex(S_BUD,3,20); ex(S_BUD,0,15); ex(S_REM,0,15);
                  ex(S_REM,3,1); ex(S_REM,5,4); ex(S_OVR,5,1); ex(S_STALL,0,0); end
        41: ex(S_OVR,5,0);
        43: begin ex(S_REM,0,6); ex(S_REM,7,20); ex(S_STALL,7,0); end
        default: ;
      endcase
    end else begin
      case (ecnt)
        0:  begin ex(S_REM,0,20); ex(S_BUD,0,20); ex(S_BUD,3,20); ex(S_OVR,5,0);
                  ex(S_UPD,0,0); ex(S_STALL,0,0); ex(S_REMB,0,20); end
        2:  ex(S_REM,0,14);
        5:  begin ex(S_BUDB,0,10); ex(S_UPDB,0,1); ex(S_REMB,0,20); end
        9:  ex(S_REM,0,14);
        10: begin ex(S_REM,0,20); ex(S_REMB,0,10); end
        19: ex(S_BUD,0,20);
        20: begin ex(S_UPD,0,1); ex(S_BUD,0,15); ex(S_BUD,3,20); end
        default: ;
      endcase
    end
  endtask

  // Inputs for the next edge (ecnt+1).
  task automatic drive_next();
    int e;
    e = ecnt + 1;
    iss_a = '0;
    if (phase == 1) begin
      if ((e >= 30 && e <= 36) || (e >= 41 && e <= 43)) iss_a[0*IW +: IW] = 5'd3;
      if (e == 32 || e == 40) iss_a[5*IW +: IW] = 5'd7;
    end else if (e <= 2) begin
      iss_a[0*IW +: IW] = 5'd3;
    end
    en_a[3] = (phase == 1 && ecnt < 25);
  endtask

  // Monitor: compare every queued expectation that falls due this cycle.
  initial begin
    exp_t e;
    int a;
    while (!done) begin
      @(negedge clk_sm);
      while (q.size() > 0 && q[0].phase == phase && q[0].cyc <= ecnt) begin
        e = q.pop_front();
        a = act(e.sig, e.lane);
        n_tests++;
        if (e.cyc != ecnt) begin
          n_fail++;
          $display("FAIL stale %s lane %0d p%0d c%0d", e.sig.name(), e.lane, e.phase, e.cyc);
        end else if (a != e.val) begin
          n_fail++;
          $display("FAIL %s lane %0d p%0d c%0d: got %0d want %0d",
                   e.sig.name(), e.lane, e.phase, e.cyc, a, e.val);
        end
      end
    end
  end

  // Driver.
  initial begin
    rst = 1'b1; phase = 1; ecnt = 0;
    v_a = '0; v_a[0*VW +: VW] = 8'd55; v_a[3*VW +: VW] = 8'd255; v_a[5*VW +: VW] = 8'd160;
    en_a = '1; iss_a = '0;
    v_b = '0; v_b[0*VW +: VW] = 8'd100; en_b = '1; iss_b = '0;
    repeat (3) @(posedge clk_sm);
    #1; rst = 1'b0; push_exp(); drive_next();
    for (int k = 1; k <= 43; k++) begin
      @(posedge clk_sm); #1;
      ecnt = k; push_exp();
      drive_next();
      if (k == 43) rst = 1'b1;
    end
    @(posedge clk_sm); #1;
    rst = 1'b0; phase = 2; ecnt = 0; push_exp(); drive_next();
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk_sm); #1;
      ecnt = k; push_exp(); drive_next();
    end
    @(negedge clk_sm); #1;
    done = 1;
    if (q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL leftover: %0d unchecked expectations, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
